// File: rtl/bt_pkg.sv
// Shared constants, types and helpers for the Bluetooth status transmitter.
package bt_pkg;

    // ASCII characters used in the status frame
    localparam logic [7:0] CH_S  = 8'h53;
    localparam logic [7:0] CH_G  = 8'h47;
    localparam logic [7:0] CH_P  = 8'h50;
    localparam logic [7:0] CH_C  = 8'h43;
    localparam logic [7:0] CH_I  = 8'h49;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    // Number of bytes in one status frame
    localparam int FRAME_LEN = 6;

    // Camera mode as reported in the status vector
    typedef enum logic [1:0] {
        MODE_I = 2'd0,
        MODE_C = 2'd1,
        MODE_P = 2'd2,
        MODE_G = 2'd3
    } mode_e;

    // Status vector S = {mode, photo slot, sd ready, camera ready}
    typedef struct packed {
        mode_e      mode;
        logic [3:0] photo;
        logic       sd_ready;
        logic       cam_ready;
    } status_t;

    // Per-byte serializer states
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // Frame sequencer states
    typedef enum logic {
        SEQ_IDLE,
        SEQ_SEND
    } seq_state_e;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    function automatic logic [7:0] mode_ascii(input mode_e m);
        case (m)
            MODE_G:  return CH_G;
            MODE_P:  return CH_P;
            MODE_C:  return CH_C;
            default: return CH_I;
        endcase
    endfunction

    // Byte idx of the frame built from a latched status snapshot
    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input status_t s);
        case (idx)
            3'd0:    return CH_S;
            3'd1:    return mode_ascii(s.mode);
            3'd2:    return hex_ascii(s.photo);
            3'd3:    return 8'h30 + {6'd0, s.sd_ready, s.cam_ready};
            3'd4:    return CH_CR;
            default: return CH_LF;
        endcase
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 serializer for a single byte with a valid/ready handshake.
// Ready is also raised in the last cycle of the stop bit so that a
// following byte starts with no idle gap on the line.
module uart_byte_tx
    import bt_pkg::*;
#(
    parameter int BAUD_DIV = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_data_i,
    output logic       byte_ready_o,
    output logic       txd_o
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);

    tx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          txd_q;
    logic          bit_end;
    logic          accept;

    assign bit_end      = (cnt_q == CNT_MAX);
    assign byte_ready_o = (state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_end);
    assign accept       = byte_valid_i && byte_ready_o;
    assign txd_o        = txd_q;

    // Baud counter and start/data/stop sequencing with a registered line output
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= TX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            txd_q     <= 1'b1;
        end else if (accept) begin
            state_q   <= TX_START;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= byte_data_i;
            txd_q     <= 1'b0;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    cnt_q <= '0;
                    txd_q <= 1'b1;
                end
                TX_START: begin
                    if (bit_end) begin
                        state_q <= TX_DATA;
                        cnt_q   <= '0;
                        txd_q   <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= TX_STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd_q     <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    if (bit_end) begin
                        state_q <= TX_IDLE;
                        cnt_q   <= '0;
                        txd_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/bluetooth_status_tx.sv
// Reports camera status to the phone as a 6-byte ASCII frame over UART.
// A frame goes out on request or whenever the status differs from the last
// one reported; changes seen during a frame collapse into one follow-up.
module bluetooth_status_tx
    import bt_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       camera_show_mode,
    input  logic       caught_photo_mode,
    input  logic       get_photo_mode,
    input  logic [3:0] select_photo_no,
    input  logic       sd_init_done,
    input  logic       camera_init_done,
    input  logic       send_req,
    output logic       bluetooth_txd,
    output logic       tx_busy,
    output logic       frame_done
);

    // Must be at least 2 so the baud counter has a real range
    localparam int BAUD_DIV = CLK_FREQ / BAUD;

    seq_state_e seq_state_q;
    status_t    status_now;
    status_t    snap_q;
    status_t    last_q;
    logic       pending_q;
    logic [2:0] byte_idx_q;
    logic       frame_done_q;

    logic       trigger;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic       accept;

    // Build the live status vector; get beats caught beats show
    always_comb begin
        status_now           = '0;
        status_now.photo     = select_photo_no;
        status_now.sd_ready  = sd_init_done;
        status_now.cam_ready = camera_init_done;
        if (get_photo_mode) begin
            status_now.mode = MODE_G;
        end else if (caught_photo_mode) begin
            status_now.mode = MODE_P;
        end else if (camera_show_mode) begin
            status_now.mode = MODE_C;
        end else begin
            status_now.mode = MODE_I;
        end
    end

    assign trigger = send_req || (status_now != last_q) || pending_q;

    // Offer the leading 'S' while idle, then the snapshot bytes in order
    always_comb begin
        byte_valid = 1'b0;
        byte_data  = CH_S;
        if (seq_state_q == SEQ_IDLE) begin
            byte_valid = trigger;
        end else begin
            byte_valid = (byte_idx_q < 3'(FRAME_LEN));
            byte_data  = frame_byte(byte_idx_q, snap_q);
        end
    end

    assign accept = byte_valid && byte_ready;

    // Frame sequencer: snapshot, pending flag and byte index
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            seq_state_q  <= SEQ_IDLE;
            snap_q       <= '0;
            last_q       <= '0;
            pending_q    <= 1'b0;
            byte_idx_q   <= 3'd0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (seq_state_q)
                SEQ_IDLE: begin
                    if (accept) begin
                        seq_state_q <= SEQ_SEND;
                        snap_q      <= status_now;
                        last_q      <= status_now;
                        pending_q   <= 1'b0;
                        byte_idx_q  <= 3'd1;
                    end
                end
                default: begin
                    if (send_req || (status_now != last_q)) begin
                        pending_q <= 1'b1;
                    end
                    if (accept) begin
                        byte_idx_q <= byte_idx_q + 3'd1;
                    end else if (byte_ready && (byte_idx_q == 3'(FRAME_LEN))) begin
                        seq_state_q  <= SEQ_IDLE;
                        byte_idx_q   <= 3'd0;
                        frame_done_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign tx_busy    = (seq_state_q == SEQ_SEND);
    assign frame_done = frame_done_q;

    uart_byte_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_byte_tx (
        .clk_i       (sys_clk),
        .rst_ni      (sys_rst_n),
        .byte_valid_i(byte_valid),
        .byte_data_i (byte_data),
        .byte_ready_o(byte_ready),
        .txd_o       (bluetooth_txd)
    );

endmodule

// File: tb/tb_bluetooth_status_tx.sv
// Directed bench for bluetooth_status_tx at BAUD_DIV = 16.
module tb_bluetooth_status_tx;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       camera_show_mode;
    logic       caught_photo_mode;
    logic       get_photo_mode;
    logic [3:0] select_photo_no;
    logic       sd_init_done;
    logic       camera_init_done;
    logic       send_req;
    logic       bluetooth_txd;
    logic       tx_busy;
    logic       frame_done;

    int vectors    = 0;
    int miscompares = 0;
    int cycleCount = 0;
    int startCyc[6];

    bluetooth_status_tx #(
        .CLK_FREQ(16),
        .BAUD    (1)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .camera_show_mode (camera_show_mode),
        .caught_photo_mode(caught_photo_mode),
        .get_photo_mode   (get_photo_mode),
        .select_photo_no  (select_photo_no),
        .sd_init_done     (sd_init_done),
        .camera_init_done (camera_init_done),
        .send_req         (send_req),
        .bluetooth_txd    (bluetooth_txd),
        .tx_busy          (tx_busy),
        .frame_done       (frame_done)
    );

    // 10 ns clock
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Free-running cycle count used to time start bits
    always @(posedge sys_clk) cycleCount <= cycleCount + 1;

    // Hard stop in case the sequence ever stalls
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic show, input logic caught, input logic get,
                                 input logic [3:0] photo, input logic sd, input logic cam,
                                 input logic req);
        camera_show_mode  = show;
        caught_photo_mode = caught;
        get_photo_mode    = get;
        select_photo_no   = photo;
        sd_init_done      = sd;
        camera_init_done  = cam;
        send_req          = req;
    endtask

    // Expected line level k cycles after the first start bit of a frame
    function automatic logic expBit(input logic [47:0] frame, input int k);
        int         bi;
        int         bp;
        logic [7:0] bv;
        bi = k / 160;
        bp = (k % 160) / 16;
        bv = 8'(frame >> (8 * (5 - bi)));
        if (bp == 0) return 1'b0;
        if (bp == 9) return 1'b1;
        return bv[bp-1];
    endfunction

    // Called at the first start-bit cycle; walks n cycles of the frame
    task automatic checkFrameCycles(input logic [47:0] frame, input int n, input string name);
        for (int k = 0; k < n; k++) begin
            checkOutput($sformatf("%s_txd_k%0d", name, k), 32'(bluetooth_txd), 32'(expBit(frame, k)));
            checkOutput($sformatf("%s_busy_k%0d", name, k), 32'(tx_busy), 32'd1);
            checkOutput($sformatf("%s_done_k%0d", name, k), 32'(frame_done), 32'd0);
            @(negedge sys_clk);
        end
    endtask

    // Called in the cycle right after the last stop bit
    task automatic checkFrameEnd(input string name);
        checkOutput({name, "_end_busy"}, 32'(tx_busy), 32'd0);
        checkOutput({name, "_end_done"}, 32'(frame_done), 32'd1);
        checkOutput({name, "_end_txd"}, 32'(bluetooth_txd), 32'd1);
        @(negedge sys_clk);
        checkOutput({name, "_done_pulse"}, 32'(frame_done), 32'd0);
    endtask

    task automatic checkIdle(input int n, input string name);
        for (int k = 0; k < n; k++) begin
            checkOutput($sformatf("%s_idle_txd_%0d", name, k), 32'(bluetooth_txd), 32'd1);
            checkOutput($sformatf("%s_idle_busy_%0d", name, k), 32'(tx_busy), 32'd0);
            @(negedge sys_clk);
        end
    endtask

    // Step until the line goes low, at most limit cycles
    task automatic waitStart(input int limit, output logic found);
        int i;
        found = 1'b0;
        i = 0;
        while (!found && i < limit) begin
            if (bluetooth_txd == 1'b0) begin
                found = 1'b1;
            end else begin
                @(negedge sys_clk);
                i++;
            end
        end
    endtask

    // Directed sequence covering power-on, idle, priority, coalescing,
    // bit timing, reset mid-frame and the remaining mode characters
    initial begin
        logic        found;
        logic [7:0]  rxByte;
        logic [47:0] expFrame;

        sys_rst_n = 1'b0;
        applyStimulus(0, 0, 0, 4'h0, 0, 0, 0);
        repeat (3) @(negedge sys_clk);
        checkOutput("rst_txd", 32'(bluetooth_txd), 32'd1);
        checkOutput("rst_busy", 32'(tx_busy), 32'd0);
        checkOutput("rst_done", 32'(frame_done), 32'd0);

        $display("[TB] power-on report");
        applyStimulus(1, 0, 0, 4'h3, 1, 1, 0);
        @(negedge sys_clk);
        checkOutput("rst_hold_txd", 32'(bluetooth_txd), 32'd1);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        checkFrameCycles(48'h5343_3333_0D0A, 960, "t1");
        checkFrameEnd("t1");
        checkIdle(100, "t1");

        $display("[TB] idle with no change");
        sys_rst_n = 1'b0;
        applyStimulus(0, 0, 0, 4'h0, 0, 0, 0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        checkIdle(2000, "t2");

        $display("[TB] forced report, get over caught");
        applyStimulus(0, 1, 1, 4'hB, 0, 0, 1);
        @(negedge sys_clk);
        send_req = 1'b0;
        checkFrameCycles(48'h5347_4230_0D0A, 960, "t3");
        checkFrameEnd("t3");
        checkIdle(50, "t3");

        $display("[TB] changes during a frame coalesce");
        applyStimulus(0, 1, 1, 4'h1, 0, 0, 0);
        @(negedge sys_clk);
        fork
            begin
                repeat (100) @(negedge sys_clk);
                select_photo_no = 4'h2;
                repeat (300) @(negedge sys_clk);
                select_photo_no = 4'h5;
            end
        join_none
        checkFrameCycles(48'h5347_3130_0D0A, 960, "t4a");
        checkFrameEnd("t4a");
        checkFrameCycles(48'h5347_3530_0D0A, 960, "t4b");
        checkFrameEnd("t4b");
        checkIdle(300, "t4");

        $display("[TB] start-bit spacing");
        expFrame = 48'h5347_3530_0D0A;
        send_req = 1'b1;
        @(negedge sys_clk);
        send_req = 1'b0;
        for (int b = 0; b < 6; b++) begin
            waitStart(400, found);
            checkOutput($sformatf("t6_start_found_%0d", b), 32'(found), 32'd1);
            startCyc[b] = cycleCount;
            if (b > 0) begin
                checkOutput($sformatf("t6_spacing_%0d", b), 32'(startCyc[b] - startCyc[b-1]), 32'd160);
            end
            repeat (8) @(negedge sys_clk);
            checkOutput($sformatf("t6_startbit_%0d", b), 32'(bluetooth_txd), 32'd0);
            rxByte = 8'h00;
            for (int j = 0; j < 8; j++) begin
                repeat (16) @(negedge sys_clk);
                rxByte[j] = bluetooth_txd;
            end
            checkOutput($sformatf("t6_byte_%0d", b), 32'(rxByte), 32'(8'(expFrame >> (8 * (5 - b)))));
            repeat (16) @(negedge sys_clk);
            checkOutput($sformatf("t6_stopbit_%0d", b), 32'(bluetooth_txd), 32'd1);
        end
        repeat (8) @(negedge sys_clk);
        checkFrameEnd("t6");
        checkIdle(20, "t6");

        $display("[TB] reset in the middle of a frame");
        send_req = 1'b1;
        @(negedge sys_clk);
        send_req = 1'b0;
        checkFrameCycles(48'h5347_3530_0D0A, 200, "t5a");
        sys_rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_txd", 32'(bluetooth_txd), 32'd1);
        checkOutput("t5_rst_busy", 32'(tx_busy), 32'd0);
        checkOutput("t5_rst_done", 32'(frame_done), 32'd0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        checkFrameCycles(48'h5347_3530_0D0A, 960, "t5b");
        checkFrameEnd("t5b");
        checkIdle(20, "t5");

        $display("[TB] idle mode, hex F, sd flag only");
        applyStimulus(0, 0, 0, 4'hF, 1, 0, 0);
        @(negedge sys_clk);
        checkFrameCycles(48'h5349_4632_0D0A, 960, "t7");
        checkFrameEnd("t7");
        checkIdle(20, "t7");

        $display("[TB] capture mode, digit 9, camera flag only");
        applyStimulus(0, 1, 0, 4'h9, 0, 1, 0);
        @(negedge sys_clk);
        checkFrameCycles(48'h5350_3931_0D0A, 960, "t8");
        checkFrameEnd("t8");
        checkIdle(20, "t8");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
